alu_writeback: RTL

- Stage directly downstream of the 16-bit ALU.
- Accepts ALU result, Z/C/V flags and destination index over a valid/ready handshake, buffers them in a 2-entry FIFO, and commits one entry per cycle into an 8x16 register file and a status-flag register.
- Two combinational read ports drive the ALU's a/b operands, closing the datapath loop.

---
 rtl/alu_writeback.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry result FIFO committing into an 8x16 register file and {V,C,Z} flags.
// Optional ALU_WB_BYPASS_EN forwards pending FIFO results onto the read ports.
module alu_writeback #(
    parameter int DATA_W     = 16,
    parameter int REG_CNT    = 8,
    parameter int ADDR_W     = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_carry,
    input  logic              in_overflow,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_flags_we,
    input  logic              wb_stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [2:0]        status_flags,
    output logic [1:0]        pending_count,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);

    localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              carry;
        logic              overflow;
        logic [ADDR_W-1:0] dest;
        logic              flags_we;
    } entry_t;

    entry_t            fifo_r [0:1];
    logic              head_r;
    logic [1:0]        count_r;
    logic [DATA_W-1:0] regs_r [0:REG_CNT-1];
    logic [2:0]        status_flags_r;
    logic              wb_valid_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;

    logic              accept_s;
    logic              commit_s;
    logic              tail_s;
    logic [1:0]        count_next_s;
    entry_t            head_entry_s;
    entry_t            in_entry_s;
    logic [ADDR_W-1:0] rd_addr_s [0:1];
    logic [DATA_W-1:0] rd_data_s [0:1];

    // in_ready looks only at occupancy, so a full FIFO refuses even when a commit frees a slot
    assign in_ready     = (count_r < DEPTH_C);
    assign accept_s     = in_valid & in_ready & ~flush;
    assign commit_s     = (count_r != 2'd0) & ~wb_stall & ~flush;
    assign tail_s       = head_r ^ count_r[0];
    assign head_entry_s = fifo_r[head_r];
    assign in_entry_s   = {in_result, in_zero, in_carry, in_overflow, in_dest, in_flags_we};

    assign rd_addr_s[0]  = rd_addr_a;
    assign rd_addr_s[1]  = rd_addr_b;
    assign rd_data_a     = rd_data_s[0];
    assign rd_data_b     = rd_data_s[1];
    assign status_flags  = status_flags_r;
    assign pending_count = count_r;
    assign wb_valid      = wb_valid_r;
    assign wb_addr       = wb_addr_r;
    assign wb_data       = wb_data_r;

    // Occupancy after this edge
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else if (accept_s && !commit_s) begin
            count_next_s = count_r + 2'd1;
        end else if (commit_s && !accept_s) begin
            count_next_s = count_r - 2'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r    <= 1'b0;
            count_r   <= 2'd0;
            fifo_r[0] <= '0;
            fifo_r[1] <= '0;
        end else begin
            count_r <= count_next_s;
            if (flush) begin
                head_r <= 1'b0;
            end else if (commit_s) begin
                head_r <= ~head_r;
            end
            if (accept_s) begin
                fifo_r[tail_s] <= in_entry_s;
            end
        end
    end

    // Register file; r0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_r[i] <= '0;
            end
        end else if (commit_s && (head_entry_s.dest != '0)) begin
            regs_r[head_entry_s.dest] <= head_entry_s.result;
        end
    end

    // Status flags and writeback observation port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_flags_r <= 3'b000;
            wb_valid_r     <= 1'b0;
            wb_addr_r      <= '0;
            wb_data_r      <= '0;
        end else begin
            wb_valid_r <= commit_s;
            if (commit_s) begin
                wb_addr_r <= head_entry_s.dest;
                wb_data_r <= head_entry_s.result;
                if (head_entry_s.flags_we) begin
                    status_flags_r <= {head_entry_s.overflow, head_entry_s.carry, head_entry_s.zero};
                end
            end
        end
    end

    // Read ports; with bypass the youngest pending entry (tail) wins over the head
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = '0;
            if (rd_addr_s[p] == '0) begin
                rd_data_s[p] = '0;
`ifdef ALU_WB_BYPASS_EN
            end else if ((count_r == 2'd2) && (fifo_r[~head_r].dest == rd_addr_s[p])) begin
                rd_data_s[p] = fifo_r[~head_r].result;
            end else if ((count_r != 2'd0) && (fifo_r[head_r].dest == rd_addr_s[p])) begin
                rd_data_s[p] = fifo_r[head_r].result;
`endif
            end else begin
                rd_data_s[p] = regs_r[rd_addr_s[p]];
            end
        end
    end

endmodule
